// File: rtl/bias_weight_store.sv
// Layer parameter store: applies load/train/inference transactions; publishes a snapshot one cycle after accept.
// Single-entry snapshot buffer; oReady_AS drops only while a snapshot is held and iReady_BS is low.
module bias_weight_store #(
  parameter int NP   = 4,
  parameter int NC   = 4,
  parameter int WD   = 8,
  parameter int WCNT = 16,
  localparam int NF  = NC + NC * NP,
  localparam int DW  = NF * WD
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iMode,
  input  logic            iLoad,
  input  logic            iValid_AS,
  output logic            oReady_AS,
  input  logic [DW-1:0]   iData_AS,
  output logic            oValid_BS,
  input  logic            iReady_BS,
  output logic [DW-1:0]   oData_BS,
  output logic [DW-1:0]   oParam,
  output logic [WCNT-1:0] oCount
);

  logic [DW-1:0]   r_param;
  logic [DW-1:0]   r_snap;
  logic            r_vld;
  logic [WCNT-1:0] r_cnt;
  logic [DW-1:0]   w_next;
  logic            w_accept;
  logic            w_train;

  // Overflow of the WD+1 bit difference shows as disagreement of its top two bits.
  function automatic logic [WD-1:0] f_sat_sub(input logic [WD-1:0] a, input logic [WD-1:0] b);
    logic [WD:0] w_diff;
    w_diff = {a[WD-1], a} - {b[WD-1], b};
    if (w_diff[WD] != w_diff[WD-1])
      f_sat_sub = w_diff[WD] ? {1'b1, {(WD-1){1'b0}}} : {1'b0, {(WD-1){1'b1}}};
    else
      f_sat_sub = w_diff[WD-1:0];
  endfunction

  assign oReady_AS = ~r_vld | iReady_BS;
  assign w_accept  = iValid_AS & oReady_AS;
  assign w_train   = ~iLoad & iMode;

  always_comb begin
    w_next = r_param;
    for (int i = 0; i < NF; i++) begin
      if (iLoad)
        w_next[i*WD +: WD] = iData_AS[i*WD +: WD];
      else if (iMode)
        w_next[i*WD +: WD] = f_sat_sub(r_param[i*WD +: WD], iData_AS[i*WD +: WD]);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_param <= '0;
      r_snap  <= '0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_param <= w_next;
      r_snap  <= w_next;
      r_vld   <= 1'b1;
      if (w_train)
        r_cnt <= r_cnt + {{(WCNT-1){1'b0}}, 1'b1};
    end else if (r_vld && iReady_BS) begin
      r_vld <= 1'b0;
    end
  end

  assign oValid_BS = r_vld;
  assign oData_BS  = r_snap;
  assign oParam    = r_param;
  assign oCount    = r_cnt;

endmodule

// File: tb/tb_bias_weight_store.sv
// Bench for bias_weight_store (NP=2, NC=2): directed table, hand sequences, randomized traffic vs. array model.
module tb_bias_weight_store;

  localparam int NP = 2;
  localparam int NC = 2;
  localparam int WD = 8;
  localparam int WCNT = 16;
  localparam int NF = NC + NC * NP;
  localparam int DW = NF * WD;

  typedef int arr_t[NF];
  typedef struct {
    bit   rst, vld, load, mode, rdy;
    arr_t d;
    arr_t e;
    int   cnt;
    bit   ev;
  } vec_t;

  logic            iCLK = 1'b0;
  logic            iRST = 1'b1;
  logic            iMode = 1'b0;
  logic            iLoad = 1'b0;
  logic            iValid_AS = 1'b0;
  logic            oReady_AS;
  logic [DW-1:0]   iData_AS = '0;
  logic            oValid_BS;
  logic            iReady_BS = 1'b1;
  logic [DW-1:0]   oData_BS;
  logic [DW-1:0]   oParam;
  logic [WCNT-1:0] oCount;

  bias_weight_store #(.NP(NP), .NC(NC), .WD(WD), .WCNT(WCNT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iLoad(iLoad),
    .iValid_AS(iValid_AS), .oReady_AS(oReady_AS), .iData_AS(iData_AS),
    .oValid_BS(oValid_BS), .iReady_BS(iReady_BS), .oData_BS(oData_BS),
    .oParam(oParam), .oCount(oCount)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: parameters as plain integers.
  arr_t m_p, m_s;
  bit   m_vld;
  int   m_cnt;
  bit   last_acc;
  vec_t tbl[11];

  function automatic logic [DW-1:0] pack(input arr_t a);
    logic [DW-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) r[f*WD +: WD] = a[f][WD-1:0];
    return r;
  endfunction

  function automatic int clamp(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit vld, input bit load, input bit mode,
                     input bit rdy, input arr_t d);
    bit exp_rdy, acc;
    iRST = rst; iValid_AS = vld; iLoad = load; iMode = mode; iReady_BS = rdy;
    iData_AS = pack(d);
    #1;
    exp_rdy = !m_vld || rdy;
    if (!rst) chk("ready", 64'(oReady_AS), 64'(exp_rdy));
    acc = !rst && vld && exp_rdy;
    last_acc = acc;
    if (rst) begin
      for (int f = 0; f < NF; f++) begin m_p[f] = 0; m_s[f] = 0; end
      m_vld = 0; m_cnt = 0;
    end else if (acc) begin
      for (int f = 0; f < NF; f++) begin
        if (load) m_p[f] = d[f];
        else if (mode) m_p[f] = clamp(m_p[f] - d[f]);
        m_s[f] = m_p[f];
      end
      m_vld = 1;
      if (!load && mode) m_cnt = (m_cnt + 1) % 65536;
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
    @(posedge iCLK); #1;
    chk("param", 64'(oParam), 64'(pack(m_p)));
    chk("snapshot", 64'(oData_BS), 64'(pack(m_s)));
    chk("valid", 64'(oValid_BS), 64'(m_vld));
    chk("count", 64'(oCount), 64'(m_cnt));
  endtask

  task automatic set_row(input int i, input bit rst, input bit vld, input bit load,
                         input bit mode, input bit rdy, input arr_t d, input arr_t e,
                         input int cnt, input bit ev);
    tbl[i].rst = rst; tbl[i].vld = vld; tbl[i].load = load; tbl[i].mode = mode;
    tbl[i].rdy = rdy; tbl[i].d = d; tbl[i].e = e; tbl[i].cnt = cnt; tbl[i].ev = ev;
  endtask

  initial begin : main
    arr_t z, ones, snap_c, nd, cur_d;
    bit cur_vld, cur_load, cur_mode;
    z = '{0, 0, 0, 0, 0, 0};
    ones = '{1, 1, 1, 1, 1, 1};
    for (int f = 0; f < NF; f++) begin m_p[f] = 0; m_s[f] = 0; end
    m_vld = 0; m_cnt = 0; last_acc = 0;

    set_row(0,  1, 1, 1, 0, 1, '{1, 2, 3, 4, 5, 6}, z, 0, 0);
    set_row(1,  1, 1, 1, 0, 1, '{1, 2, 3, 4, 5, 6}, z, 0, 0);
    set_row(2,  0, 0, 0, 0, 1, z, z, 0, 0);
    set_row(3,  0, 1, 1, 0, 1, '{5, -3, 10, 20, 30, 40}, '{5, -3, 10, 20, 30, 40}, 0, 1);
    set_row(4,  0, 1, 0, 1, 1, '{2, -1, 1, 1, 1, 1}, '{3, -2, 9, 19, 29, 39}, 1, 1);
    set_row(5,  0, 1, 0, 0, 1, '{2, -1, 1, 1, 1, 1}, '{3, -2, 9, 19, 29, 39}, 1, 1);
    set_row(6,  0, 0, 0, 0, 1, z, '{3, -2, 9, 19, 29, 39}, 1, 0);
    set_row(7,  0, 1, 1, 0, 1, '{0, 0, 120, -120, 0, 0}, '{0, 0, 120, -120, 0, 0}, 1, 1);
    set_row(8,  0, 1, 0, 1, 1, '{0, 0, -20, 20, 0, 0}, '{0, 0, 127, -128, 0, 0}, 2, 1);
    set_row(9,  0, 1, 1, 1, 1, '{1, 2, 3, 4, 5, 6}, '{1, 2, 3, 4, 5, 6}, 2, 1);
    set_row(10, 0, 1, 0, 1, 1, '{-128, 127, 0, 0, 0, 0}, '{127, -125, 3, 4, 5, 6}, 3, 1);

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].vld, tbl[i].load, tbl[i].mode, tbl[i].rdy, tbl[i].d);
      chk($sformatf("row%0d_param", i), 64'(oParam), 64'(pack(tbl[i].e)));
      chk($sformatf("row%0d_count", i), 64'(oCount), 64'(tbl[i].cnt));
      chk($sformatf("row%0d_valid", i), 64'(oValid_BS), 64'(tbl[i].ev));
      if (i == 2) chk("reset_ready", 64'(oReady_AS), 64'(1));
    end

    // Backpressure: snapshot held, new transaction waits.
    snap_c = '{127, -125, 3, 4, 5, 6};
    nd = '{-7, 8, -9, 10, -11, 12};
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 0, 0, nd);
      chk("bp_ready", 64'(oReady_AS), 64'(0));
      chk("bp_snap", 64'(oData_BS), 64'(pack(snap_c)));
      chk("bp_param", 64'(oParam), 64'(pack(snap_c)));
    end
    cyc(0, 1, 1, 0, 1, nd);
    chk("bp_release_valid", 64'(oValid_BS), 64'(1));
    chk("bp_release_snap", 64'(oData_BS), 64'(pack(nd)));

    // Streaming after reset, then reset with a pending snapshot.
    cyc(1, 0, 0, 0, 1, z);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1, 0, 1, 1, ones);
      chk("stream_valid", 64'(oValid_BS), 64'(1));
      chk("stream_param", 64'(oParam), 64'(pack('{-k, -k, -k, -k, -k, -k})));
    end
    chk("stream_count", 64'(oCount), 64'(4));
    cyc(1, 1, 1, 0, 0, ones);
    chk("rst_valid", 64'(oValid_BS), 64'(0));
    chk("rst_param", 64'(oParam), 64'(0));
    chk("rst_snap", 64'(oData_BS), 64'(0));
    chk("rst_count", 64'(oCount), 64'(0));
    cyc(0, 0, 0, 0, 1, z);

    // Randomized traffic honouring the hold-while-stalled rule.
    cur_vld = 0; cur_load = 0; cur_mode = 0; cur_d = z; last_acc = 0;
    for (int n = 0; n < 400; n++) begin
      bit rst_r;
      if (!(cur_vld && !last_acc)) begin
        cur_vld  = ($urandom_range(0, 3) != 0);
        cur_load = ($urandom_range(0, 4) == 0);
        cur_mode = ($urandom_range(0, 3) != 0);
        for (int f = 0; f < NF; f++) begin
          logic [7:0] b;
          b = 8'($urandom);
          cur_d[f] = int'($signed(b));
        end
      end
      rst_r = ($urandom_range(0, 59) == 0);
      cyc(rst_r, cur_vld, cur_load, cur_mode, 1'($urandom_range(0, 2) != 0), cur_d);
      if (rst_r) last_acc = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
